// File: rtl/alu_share_arbiter.sv
// Round-robin front end that lets N_REQ requesters share one combinational ALU.
// Each transaction: grant (IDLE), ALU settle (EXEC), hold response until accepted (RESP).
module alu_share_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    input  logic [3*N_REQ-1:0]   req_op,
    output logic [31:0]          alu_src1,
    output logic [31:0]          alu_src2,
    output logic [2:0]           alu_ctrl,
    input  logic [31:0]          alu_result,
    input  logic                 alu_zero,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [31:0]          rsp_data,
    output logic                 rsp_zero,
    output logic                 rsp_illegal,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          op_count
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t             r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [31:0]        r_alu_src1;
    logic [31:0]        r_alu_src2;
    logic [2:0]         r_alu_ctrl;
    logic [N_REQ-1:0]   r_rsp_valid;
    logic [31:0]        r_rsp_data;
    logic               r_rsp_zero;
    logic               r_rsp_illegal;
    logic [ID_W-1:0]    r_rsp_id;
    logic [15:0]        r_op_count;

    logic               w_found;
    logic [ID_W-1:0]    w_grant;
    logic [N_REQ-1:0]   w_grant_onehot;
    logic [31:0]        w_a;
    logic [31:0]        w_b;
    logic [2:0]         w_op;
    logic [N_REQ-1:0]   w_id_onehot;
    logic               w_rsp_hs;

    // Search starts one past the last grant so a persistent requester cannot starve others.
    always_comb begin
        w_found        = 1'b0;
        w_grant        = '0;
        w_grant_onehot = '0;
        w_a            = '0;
        w_b            = '0;
        w_op           = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!w_found && req_valid[i] && (i == ((int'(r_ptr) + k) % N_REQ))) begin
                    w_found           = 1'b1;
                    w_grant           = ID_W'(i);
                    w_grant_onehot[i] = 1'b1;
                    w_a               = req_a[32*i +: 32];
                    w_b               = req_b[32*i +: 32];
                    w_op              = req_op[3*i +: 3];
                end
            end
        end
    end

    always_comb begin
        w_id_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_id_onehot[i] = (int'(r_rsp_id) == i);
        end
        w_rsp_hs = |(rsp_ready & w_id_onehot);
    end

    assign req_ready = (r_state == S_IDLE && w_found) ? w_grant_onehot : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ptr         <= ID_W'(N_REQ - 1);
            r_alu_src1    <= '0;
            r_alu_src2    <= '0;
            r_alu_ctrl    <= '0;
            r_rsp_valid   <= '0;
            r_rsp_data    <= '0;
            r_rsp_zero    <= 1'b0;
            r_rsp_illegal <= 1'b0;
            r_rsp_id      <= '0;
            r_op_count    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_alu_src1 <= w_a;
                        r_alu_src2 <= w_b;
                        r_alu_ctrl <= w_op;
                        r_ptr      <= w_grant;
                        r_rsp_id   <= w_grant;
                        r_state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_data    <= alu_result;
                    r_rsp_zero    <= alu_zero;
                    r_rsp_illegal <= (r_alu_ctrl == 3'd4) || (r_alu_ctrl == 3'd5);
                    r_rsp_valid   <= w_id_onehot;
                    r_state       <= S_RESP;
                end
                S_RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= '0;
                        r_op_count  <= r_op_count + 16'd1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign alu_src1    = r_alu_src1;
    assign alu_src2    = r_alu_src2;
    assign alu_ctrl    = r_alu_ctrl;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_zero    = r_rsp_zero;
    assign rsp_illegal = r_rsp_illegal;
    assign rsp_id      = r_rsp_id;
    assign op_count    = r_op_count;

endmodule
